// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: NOP encoding, PC width and
// the RUN/PARK state encoding.
package fetch_stage_pkg;

  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PARK = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Bubble beats load; with neither asserted the
// contents hold.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            bubble,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic [PC_W-1:0] pc_plus4_in,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, RUN/PARK FSM and IF/ID.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic [PC_W-1:0] ifid_pc_plus4,
  output logic            out_of_range,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stalled,
`endif
  output logic            misalign_err
);

  localparam logic [PC_W:0] IMEM_BYTES = (PC_W+1)'(4 * IMEM_DEPTH);

  function automatic logic in_range(input logic [PC_W-1:0] addr);
    return {1'b0, addr} < IMEM_BYTES;
  endfunction

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redir_target;
  logic            ifid_load, ifid_bubble;

  assign pc_plus4     = pc_q + 32'd4;
  assign redir_target = {redirect_pc[PC_W-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (redirect_valid) begin
      // A redirect out of range parks immediately so that address is never fetched.
      pc_d        = redir_target;
      ifid_bubble = 1'b1;
      state_d     = in_range(redir_target) ? ST_RUN : ST_PARK;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (state_q == ST_PARK) begin
      ifid_bubble = 1'b1;
    end else if (stall) begin
      ifid_bubble = flush;
    end else begin
      pc_d        = pc_plus4;
      state_d     = in_range(pc_plus4) ? ST_RUN : ST_PARK;
      ifid_bubble = flush;
      ifid_load   = !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RESET;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_of_range = (state_q == ST_PARK);
  assign misalign_err = misalign_q;

  ifid_reg u_ifid_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .bubble      (ifid_bubble),
    .instr_in    (imem_instr),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_plus4),
    .valid       (ifid_valid),
    .instr       (ifid_instr),
    .pc          (ifid_pc),
    .pc_plus4    (ifid_pc_plus4)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalled_q, stalled_d;

  always_comb begin
    fetched_d = fetched_q + 32'(ifid_load);
    stalled_d = stalled_q + 32'((state_q == ST_RUN) && stall && !redirect_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stalled_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalled_q <= stalled_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalled = stalled_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 4-word instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_instr;
  logic        ifid_valid, out_of_range, misalign_err;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stalled;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] M0 = 32'h2009_0002;
  localparam logic [31:0] M1 = 32'h2108_0001;
  localparam logic [31:0] M2 = 32'h1509_FFFE;
  localparam logic [31:0] M3 = 32'h8C0A_0000;

  logic [31:0] mem [4];
  assign imem_instr = (imem_addr < 32'd16) ? mem[imem_addr[3:2]] : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(32'h0), .IMEM_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .out_of_range   (out_of_range),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stalled   (perf_stalled),
`endif
    .misalign_err   (misalign_err)
  );

  typedef struct {
    logic        rst, st, fl, rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_addr;
    logic        e_oor, e_mis;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic rst, logic st, logic fl, logic rv, logic [31:0] rpc,
                              logic ev, logic [31:0] ei, logic [31:0] ep, logic [31:0] ea,
                              logic eo, logic em);
    vec_t v;
    v.rst = rst; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_addr = ea;
    v.e_oor = eo; v.e_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(ifid_valid), 32'(v.e_valid));
    check({tag, ".instr"}, ifid_instr, v.e_instr);
    check({tag, ".addr"}, imem_addr, v.e_addr);
    check({tag, ".oor"}, 32'(out_of_range), 32'(v.e_oor));
    check({tag, ".mis"}, 32'(misalign_err), 32'(v.e_mis));
    if (v.e_valid) begin
      check({tag, ".pc"}, ifid_pc, v.e_pc);
      check({tag, ".pc4"}, ifid_pc_plus4, v.e_pc + 32'd4);
    end
  endtask

  initial begin
    mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = M3;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    //             rst st fl rv rpc     | valid instr pc     addr   oor mis
    vecs[0]  = mk(1, 0, 0, 0, 32'd0,    0, 32'h0, 32'd0,  32'd0,  0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 32'd0,    1, M0,    32'd0,  32'd4,  0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 32'd0,    1, M1,    32'd4,  32'd8,  0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 32'd0,    1, M1,    32'd4,  32'd8,  0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 32'd0,    1, M1,    32'd4,  32'd8,  0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 32'd0,    1, M1,    32'd4,  32'd8,  0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'd0,    1, M2,    32'd8,  32'd12, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 32'd4,    0, 32'h0, 32'd0,  32'd4,  0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'd0,    1, M1,    32'd4,  32'd8,  0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 32'd0,    1, M2,    32'd8,  32'd12, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 32'd0,    1, M3,    32'd12, 32'd16, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 32'd0,    0, 32'h0, 32'd0,  32'd16, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 32'd0,    0, 32'h0, 32'd0,  32'd16, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 32'd0,    0, 32'h0, 32'd0,  32'd0,  0, 0);
    vecs[14] = mk(0, 0, 0, 0, 32'd0,    1, M0,    32'd0,  32'd4,  0, 0);
    vecs[15] = mk(0, 0, 1, 0, 32'd0,    0, 32'h0, 32'd0,  32'd8,  0, 0);
    vecs[16] = mk(0, 0, 0, 0, 32'd0,    1, M2,    32'd8,  32'd12, 0, 0);
    vecs[17] = mk(0, 1, 1, 0, 32'd0,    0, 32'h0, 32'd0,  32'd12, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 32'd0,    1, M3,    32'd12, 32'd16, 1, 0);
    vecs[19] = mk(0, 0, 0, 1, 32'd32,   0, 32'h0, 32'd0,  32'd32, 1, 0);
    vecs[20] = mk(0, 0, 0, 1, 32'd4,    0, 32'h0, 32'd0,  32'd4,  0, 0);
    vecs[21] = mk(0, 0, 0, 0, 32'd0,    1, M1,    32'd4,  32'd8,  0, 0);

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].rpc);
      check_state($sformatf("vec%0d", i), vecs[i]);
`ifdef FETCH_PERF_CNT_EN
      if (i == 2) check("perf_fetched_pre_stall", perf_fetched, 32'd2);
      if (i == 5) begin
        check("perf_fetched_in_stall", perf_fetched, 32'd2);
        check("perf_stalled_in_stall", perf_stalled, 32'd3);
      end
      if (i == 7) check("perf_stalled_redirect", perf_stalled, 32'd3);
`endif
    end

    // Misaligned redirect: target forced to word boundary, error sticks.
    apply(0, 0, 0, 1, 32'h0000_0006);
    check("mis_redir.addr", imem_addr, 32'd4);
    check("mis_redir.mis", 32'(misalign_err), 32'd1);
    check("mis_redir.valid", 32'(ifid_valid), 32'd0);
    apply(0, 0, 0, 0, 32'd0);
    check("mis_fetch.pc", ifid_pc, 32'd4);
    check("mis_fetch.instr", ifid_instr, M1);
    check("mis_sticky1", 32'(misalign_err), 32'd1);
    apply(0, 0, 0, 0, 32'd0);
    apply(0, 0, 0, 0, 32'd0);
    check("mis_park.oor", 32'(out_of_range), 32'd1);
    check("mis_park.addr", imem_addr, 32'd16);
    check("mis_sticky2", 32'(misalign_err), 32'd1);

    // Reset while parked beats flush and redirect at the same edge.
    apply(1, 0, 1, 1, 32'd8);
    check("rst_park.addr", imem_addr, 32'd0);
    check("rst_park.valid", 32'(ifid_valid), 32'd0);
    check("rst_park.oor", 32'(out_of_range), 32'd0);
    check("rst_park.mis", 32'(misalign_err), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_park.perf_fetched", perf_fetched, 32'd0);
`endif
    apply(0, 0, 0, 0, 32'd0);
    check("post_rst.valid", 32'(ifid_valid), 32'd1);
    check("post_rst.pc", ifid_pc, 32'd0);
    check("post_rst.instr", ifid_instr, M0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
